// File: rtl/digit_serial_adder.sv
// Digit-serial unsigned adder: consumes both operands two bits per clock through
// one 2-bit add slice, with the inter-slice carry held in a register.
module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             carry
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [2:0]       slice;
  logic [WIDTH+1:0] acc_shift;

  function automatic logic [2:0] add_slice(input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic       cin);
    return {1'b0, a} + {1'b0, b} + {2'b00, cin};
  endfunction

  always_comb begin
    slice     = add_slice(xs_q[1:0], ys_q[1:0], c_q);
    // New sum digit enters at the MSB end; after the last slice digit 0 sits at [1:0].
    acc_shift = {slice[1:0], acc_q};

    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    z_d     = z_q;
    carry_d = carry_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          acc_d   = '0;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        xs_d  = xs_q >> 2;
        ys_d  = ys_q >> 2;
        acc_d = acc_shift[WIDTH+1:2];
        c_d   = slice[2];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          z_d     = acc_shift[WIDTH+1:2];
          carry_d = slice[2];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign z     = z_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: a latency/result model plus literal
// expectations for each vector.
module tb_digit_serial_adder;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] x, y;
  logic             busy, done, carry;
  logic [WIDTH-1:0] z;

  int checks   = 0;
  int failures = 0;

  digit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: an accepted request yields x+y exactly LAT edges later.
  bit             m_busy  = 1'b0;
  int             m_left  = 0;
  bit [WIDTH:0]   m_pend  = '0;
  bit             m_done  = 1'b0;
  bit [WIDTH-1:0] m_z     = '0;
  bit             m_carry = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_left = 0; m_pend = '0;
      m_done = 1'b0; m_z = '0; m_carry = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_carry, m_z} = m_pend;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = LAT;
        m_pend = {1'b0, x} + {1'b0, y};
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Every stimulus step advances through here, so the model is compared every cycle.
  task automatic tick();
    @(negedge clk);
    chk("model_busy",  {31'd0, busy},  {31'd0, m_busy});
    chk("model_done",  {31'd0, done},  {31'd0, m_done});
    chk("model_z",     {24'd0, z},     {24'd0, m_z});
    chk("model_carry", {31'd0, carry}, {31'd0, m_carry});
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    x = a; y = b; start = 1'b1;
    tick();
    start = 1'b0;
    x = ~a; y = ~b;
  endtask

  task automatic wait_done(input int n0, output int n, output int nb);
    n = n0; nb = 0;
    while (!done && n < 12) begin
      if (busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic check_res(input string nm, input int n,
                           input logic [WIDTH-1:0] ez, input logic ec);
    chk({nm, "_latency"}, n, LAT);
    chk({nm, "_z"}, {24'd0, z}, {24'd0, ez});
    chk({nm, "_carry"}, {31'd0, carry}, {31'd0, ec});
  endtask

  task automatic run_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ez, input logic ec);
    int n, nb;
    launch(a, b);
    wait_done(0, n, nb);
    check_res(nm, n, ez, ec);
    chk({nm, "_busy_cycles"}, nb, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nb, ndone;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_z", {24'd0, z}, 0);
    chk("reset_carry", {31'd0, carry}, 0);
    rst_n = 1'b1;
    tick();

    run_op("zero", 8'd0, 8'd0, 8'd0, 1'b0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
    run_op("one_plus_zero", 8'd1, 8'd0, 8'd1, 1'b0);
    run_op("one_plus_one", 8'd1, 8'd1, 8'd2, 1'b0);
    run_op("max_plus_max", 8'd255, 8'd255, 8'd254, 1'b1);
    run_op("full_ripple", 8'h55, 8'hAB, 8'h00, 1'b1);

    // start pulsed while busy is ignored
    tick();
    launch(8'd100, 8'd50);
    tick();
    x = 8'd3; y = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, n, nb);
    check_res("busy_start_ignored", n, 8'd150, 1'b0);
    ndone = 0;
    repeat (6) begin
      tick();
      if (done) ndone++;
    end
    chk("no_second_done", ndone, 0);
    chk("busy_after_ignore", {31'd0, busy}, 0);
    chk("z_after_ignore", {24'd0, z}, 150);

    // back-to-back: start accepted in the done cycle, z holds meanwhile
    launch(8'd20, 8'd30);
    wait_done(0, n, nb);
    check_res("b2b_first", n, 8'd50, 1'b0);
    launch(8'd3, 8'd3);
    n = 0;
    while (!done && n < 12) begin
      chk("b2b_z_hold", {24'd0, z}, 50);
      tick();
      n++;
    end
    check_res("b2b_second", n, 8'd6, 1'b0);

    // asynchronous reset mid-operation
    tick();
    launch(8'd200, 8'd100);
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_done", {31'd0, done}, 0);
    chk("async_rst_z", {24'd0, z}, 0);
    chk("async_rst_carry", {31'd0, carry}, 0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      tick();
      if (done) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    run_op("after_reset", 8'd10, 8'd20, 8'd30, 1'b0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
